alu_serial_ctrl: RTL
====================

Name: alu_serial_ctrl

Overview:
- Bit-serial ALU sequencer: performs one WIDTH-bit ALU operation by stepping a single alu_bottom 1-bit slice across all bit positions, LSB first, one bit per clock.
- Holds the carry chain in a register and assembles the result in a shift register.
- For set-less-than, adds a final fix-up cycle that writes the less bit into result[0].
- Sits between the lab CPU decode stage and the slice, as a low-area replacement for the ripple ALU. Uses a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).
- IDX_W, 5, bit-index counter width; must satisfy 2^IDX_W ≥ WIDTH.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous active-high reset.
- start_i  input  1  request; accepted only in IDLE.
- src1_i  input  WIDTH  operand A.
- src2_i  input  WIDTH  operand B.
- ALU_control_i  input  4  {A_invert, B_invert, operation[1:0]}.
- busy_o  output  1  high from the cycle after acceptance until done.
- done_o  output  1  one-cycle pulse; outputs valid.
- result_o  output  WIDTH  result, held until next acceptance.
- zero_o  output  1  result_o == 0.
- cout_o  output  1  MSB carry-out; 0 unless operation is 10 or 11.
- overflow_o  output  1  signed overflow from MSB slice; 0 unless operation is 10 or 11.

Behaviour:
- Reset (synchronous): state=IDLE; busy_o, done_o, cout_o, overflow_o = 0; result_o = 0; zero_o = 1; carry and index registers = 0.
- Reset asserted mid-operation aborts the operation and applies the same values; the next start is handled normally.
- States: IDLE, RUN, FIX, DONE.
- IDLE, start_i=1: latch src1_i, src2_i, ALU_control_i; clear the result shift register; carry = B_invert; idx = 0; go to RUN. busy_o=1 from the next cycle.
- RUN, each cycle:
  - Drive the slice with A[idx], B[idx], carry, the latched invert bits and operation; less = 0.
  - Write the slice result into result bit idx; carry <= slice cout.
  - At idx = WIDTH-1: capture cout_o and overflow_o from the slice, and capture set = slice set. If operation==11, go to FIX; else go to DONE. Otherwise idx++.
- FIX (operation 11 only): result[0] <= set XOR overflow (signed less). All other bits stay 0.
- DONE: done_o=1 for exactly one cycle; busy_o=0; zero_o updated; go to IDLE.
- Outputs hold their values until the next accepted start; the first RUN cycle clears result_o.
- Latency: start accepted at edge T, done_o high in cycle T+WIDTH+1; T+WIDTH+2 for operation 11.
- start_i while busy or in DONE is ignored; no queuing. start_i in the cycle after done (IDLE) is accepted.
- Input ports are don't-care after acceptance; changes are not observed.
- Any 4-bit code executes by field decode.
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
  - Other codes produce whatever the field decode yields; no error flag.
- No combinational path from inputs to outputs.

Test Plan:
- ADD (0010), 0x7FFFFFFF + 0x00000001 -> done 33 cycles after accept; result 0x80000000, overflow 1, cout 0, zero 0.
- SUB (0110), 5 − 5 -> result 0, zero 1, cout 1, overflow 0.
- SLT (0111):
  - src1 0xFFFFFFFF, src2 0x00000001 -> result 0x00000001, done 34 cycles after accept.
  - src1 0x80000000, src2 0x00000001 (overflow case) -> result 1.
  - src1 5, src2 3 -> result 0, zero 1.
- NOR (1100), 0x0F0F0F0F, 0x00FF00FF -> result 0xF000F000, cout 0, overflow 0. AND/OR on the same operands -> 0x000F000F and 0x0FFF0FFF.
- Handshake: pulse start during RUN with different operands -> ignored, and the original result is returned. Assert start the cycle after done -> accepted, and busy rises next cycle.
- Reset at idx=10 of an ADD -> next cycle busy 0, result 0, zero 1, no done pulse. A following ADD 3+4 -> result 7.

Source files
------------

// File: rtl/alu_serial_ctrl_if.sv
// rtl/alu_serial_ctrl_if.sv - start/busy/done handshake and operand/result bus of the serial ALU
interface alu_serial_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start_i;
   logic [WIDTH-1:0] src1_i;
   logic [WIDTH-1:0] src2_i;
   logic [3:0]       ALU_control_i;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] result_o;
   logic             zero_o;
   logic             cout_o;
   logic             overflow_o;

   modport master (
      output start_i, src1_i, src2_i, ALU_control_i,
      input  busy_o, done_o, result_o, zero_o, cout_o, overflow_o
   );

   modport slave (
      input  start_i, src1_i, src2_i, ALU_control_i,
      output busy_o, done_o, result_o, zero_o, cout_o, overflow_o
   );
endinterface

// File: rtl/alu_serial_ctrl.sv
// rtl/alu_serial_ctrl.sv - bit-serial ALU sequencer driving one 1-bit slice LSB first
module alu_serial_ctrl #(
   parameter int WIDTH = 32,
   parameter int IDX_W = 5
) (
   input  logic         clk_i,
   input  logic         rst_i,
   alu_serial_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, res, res_nxt;
   logic [IDX_W-1:0] idx;
   logic             carry, a_inv, b_inv;
   logic [1:0]       op;
   logic             set_r, ovf_raw, cout_r, ovf_r, zero_r;
   logic             busy, done, last;
   logic             sa, sb, s_sum, s_cout, s_res, s_ovf;

   // One alu_bottom slice; less is tied low, the SLT answer is patched in FIX
   always_comb begin
      sa     = a_sh[0] ^ a_inv;
      sb     = b_sh[0] ^ b_inv;
      s_sum  = sa ^ sb ^ carry;
      s_cout = (sa & sb) | (sa & carry) | (sb & carry);
      s_ovf  = carry ^ s_cout;
      case (op)
         2'b00:   s_res = sa & sb;
         2'b01:   s_res = sa | sb;
         2'b10:   s_res = s_sum;
         default: s_res = 1'b0;
      endcase
   end

   assign last = (idx == IDX_W'(WIDTH - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      res_nxt   = res;
      case (state)
         IDLE: if (bus.start_i) state_nxt = RUN;
         RUN: begin
            busy    = 1'b1;
            res_nxt = {s_res, res[WIDTH-1:1]};
            if (last) state_nxt = (op == 2'b11) ? FIX : DONE;
         end
         FIX: begin
            busy      = 1'b1;
            res_nxt   = {{(WIDTH-1){1'b0}}, set_r ^ ovf_raw};
            state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operands are shifted right so the active bit is always at position 0
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_sh    <= '0;
         b_sh    <= '0;
         res     <= '0;
         idx     <= '0;
         carry   <= 1'b0;
         a_inv   <= 1'b0;
         b_inv   <= 1'b0;
         op      <= 2'b00;
         set_r   <= 1'b0;
         ovf_raw <= 1'b0;
         cout_r  <= 1'b0;
         ovf_r   <= 1'b0;
         zero_r  <= 1'b1;
      end else begin
         case (state)
            IDLE: if (bus.start_i) begin
               a_sh   <= bus.src1_i;
               b_sh   <= bus.src2_i;
               a_inv  <= bus.ALU_control_i[3];
               b_inv  <= bus.ALU_control_i[2];
               op     <= bus.ALU_control_i[1:0];
               carry  <= bus.ALU_control_i[2];
               res    <= '0;
               idx    <= '0;
               cout_r <= 1'b0;
               ovf_r  <= 1'b0;
            end
            RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               carry <= s_cout;
               res   <= res_nxt;
               if (last) begin
                  cout_r  <= op[1] & s_cout;
                  ovf_r   <= op[1] & s_ovf;
                  set_r   <= s_sum;
                  ovf_raw <= s_ovf;
                  if (op != 2'b11) zero_r <= (res_nxt == '0);
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            FIX: begin
               res    <= res_nxt;
               zero_r <= (res_nxt == '0);
            end
            default: ;
         endcase
      end
   end

   assign bus.busy_o     = busy;
   assign bus.done_o     = done;
   assign bus.result_o   = res;
   assign bus.zero_o     = zero_r;
   assign bus.cout_o     = cout_r;
   assign bus.overflow_o = ovf_r;
endmodule
